// File: rtl/snd_pkg.sv
// Shared types, constants and helpers for the expansion-audio mixer.
package snd_pkg;

   localparam int SND_W    = 16;
   localparam int WIDE_W   = 48;
   localparam int UNITY_SH = 7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      SAT  = 2'd2,
      FLT  = 2'd3
   } snd_st_t;

   // Clamp a wide unsigned level into the 16-bit DAC range.
   function automatic logic [SND_W-1:0] sat16(input logic [WIDE_W-1:0] v);
      logic [SND_W-1:0] r;
      if (v > WIDE_W'(16'hFFFF)) begin
         r = 16'hFFFF;
      end else begin
         r = v[SND_W-1:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/snd_lpf.sv
// One-pole low-pass: y += (mix - y) >>> LPF_SH on each enabled cycle.
module snd_lpf
   import snd_pkg::*;
#(
   parameter int LPF_SH = 3
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [SND_W-1:0] mix,
   output logic [SND_W-1:0] y
);

   logic signed [SND_W:0] diff_s;
   logic signed [SND_W:0] step_s;
   logic [SND_W-1:0]      y_nx_s;

   // Signed step toward the target; the arithmetic shift floors negative steps.
   always_comb begin
      diff_s = $signed({1'b0, mix}) - $signed({1'b0, y});
      step_s = diff_s >>> LPF_SH;
      if (LPF_SH == 0) begin
         y_nx_s = mix;
      end else begin
         y_nx_s = SND_W'($signed({1'b0, y}) + step_s);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         y <= {SND_W{1'b0}};
      end else if (en) begin
         y <= y_nx_s;
      end
   end

endmodule

// File: rtl/snd_mix.sv
// Expansion-audio mixer: per-channel gain, saturating sum and low-pass,
// one mix per M2 falling edge through a single time-multiplexed MAC.
module snd_mix
   import snd_pkg::*;
#(
   parameter int CH_NUM = 4,
   parameter int IN_W   = 12,
   parameter int GAIN_W = 8,
   parameter int LPF_SH = 3
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     m2,
   input  logic [CH_NUM*IN_W-1:0]   ch_in,
   input  logic [CH_NUM*GAIN_W-1:0] gain,
   input  logic [CH_NUM-1:0]        ch_en,
   output logic [SND_W-1:0]         snd,
   output logic                     snd_stb,
   output logic                     busy,
   output logic                     ovf
);

   localparam int IDX_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
   localparam int PROD_W = IN_W + GAIN_W;
   localparam int ACC_W  = IN_W + GAIN_W + $clog2(CH_NUM);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CH_NUM - 1);

   logic [1:0]               m2_st;
   logic                     edge_s;
   snd_st_t                  state_r;
   snd_st_t                  state_nx;
   logic                     start_s;
   logic                     flt_en_s;
   logic                     pend;
   logic [IDX_W-1:0]         ch_idx;
   logic [ACC_W-1:0]         acc;
   logic [CH_NUM*IN_W-1:0]   ch_snap_r;
   logic [CH_NUM*GAIN_W-1:0] gain_snap_r;
   logic [CH_NUM-1:0]        en_snap_r;
   logic [IN_W-1:0]          smp_s;
   logic [GAIN_W-1:0]        gn_s;
   logic [PROD_W-1:0]        prod_s;
   logic [SND_W-1:0]         mix_r;

   // m2_st[1] is the older sample, so 1->0 across the pair is a falling edge.
   assign edge_s = m2_st[1] & ~m2_st[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         m2_st <= 2'b00;
      end else begin
         m2_st <= {m2_st[0], m2};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx;
      end
   end

   always_comb begin
      state_nx = state_r;
      start_s  = 1'b0;
      flt_en_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (edge_s || pend) begin
               start_s  = 1'b1;
               state_nx = MAC;
            end else begin
               state_nx = IDLE;
            end
         end
         MAC: begin
            if (ch_idx == LAST_IDX) begin
               state_nx = SAT;
            end else begin
               state_nx = MAC;
            end
         end
         SAT: begin
            state_nx = FLT;
         end
         FLT: begin
            flt_en_s = 1'b1;
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // One-deep pending start; an edge arriving while one is already queued is lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend <= 1'b0;
         ovf  <= 1'b0;
      end else if (state_r == IDLE) begin
         pend <= pend & edge_s;
      end else if (edge_s) begin
         if (pend) begin
            ovf <= 1'b1;
         end else begin
            pend <= 1'b1;
         end
      end
   end

   always_comb begin
      if (en_snap_r[ch_idx]) begin
         smp_s = ch_snap_r[int'(ch_idx)*IN_W +: IN_W];
      end else begin
         smp_s = {IN_W{1'b0}};
      end
      gn_s   = gain_snap_r[int'(ch_idx)*GAIN_W +: GAIN_W];
      prod_s = PROD_W'(smp_s) * PROD_W'(gn_s);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ch_idx      <= {IDX_W{1'b0}};
         acc         <= {ACC_W{1'b0}};
         mix_r       <= {SND_W{1'b0}};
         ch_snap_r   <= {(CH_NUM*IN_W){1'b0}};
         gain_snap_r <= {(CH_NUM*GAIN_W){1'b0}};
         en_snap_r   <= {CH_NUM{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (start_s) begin
                  ch_snap_r   <= ch_in;
                  gain_snap_r <= gain;
                  en_snap_r   <= ch_en;
                  ch_idx      <= {IDX_W{1'b0}};
                  acc         <= {ACC_W{1'b0}};
               end
            end
            MAC: begin
               acc <= acc + ACC_W'(prod_s);
               if (ch_idx == LAST_IDX) begin
                  ch_idx <= {IDX_W{1'b0}};
               end else begin
                  ch_idx <= ch_idx + IDX_W'(1);
               end
            end
            SAT: begin
               // Drop the unity-gain scale, then left-justify the sample width to 16 bits.
               mix_r <= sat16(WIDE_W'(acc >> UNITY_SH) << (SND_W - IN_W));
            end
            FLT: begin
               mix_r <= mix_r;
            end
            default: begin
               ch_idx <= {IDX_W{1'b0}};
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         snd_stb <= 1'b0;
         busy    <= 1'b0;
      end else begin
         snd_stb <= flt_en_s;
         busy    <= (state_nx != IDLE);
      end
   end

   snd_lpf #(
      .LPF_SH (LPF_SH)
   ) u_lpf (
      .clk (clk),
      .rst (rst),
      .en  (flt_en_s),
      .mix (mix_r),
      .y   (snd)
   );

endmodule

// File: tb/tb_snd_mix.sv
// Bench for snd_mix: a bypass instance and a filtered instance share stimulus
// and are compared against a plain-arithmetic mixer/filter model.
module tb_snd_mix;

   logic        clk;
   logic        rst;
   logic        m2;
   logic [47:0] ch_in;
   logic [31:0] gain;
   logic [3:0]  ch_en;
   logic [15:0] snd0, snd3;
   logic        snd_stb0, snd_stb3;
   logic        busy0, busy3;
   logic        ovf0, ovf3;

   int          n_vec = 0;
   int          n_bad = 0;
   int          stb_cnt = 0;
   logic [15:0] y0 = 16'd0;
   logic [15:0] y3 = 16'd0;

   snd_mix #(.CH_NUM(4), .IN_W(12), .GAIN_W(8), .LPF_SH(0)) dut0 (
      .clk(clk), .rst(rst), .m2(m2), .ch_in(ch_in), .gain(gain), .ch_en(ch_en),
      .snd(snd0), .snd_stb(snd_stb0), .busy(busy0), .ovf(ovf0)
   );

   snd_mix #(.CH_NUM(4), .IN_W(12), .GAIN_W(8), .LPF_SH(3)) dut3 (
      .clk(clk), .rst(rst), .m2(m2), .ch_in(ch_in), .gain(gain), .ch_en(ch_en),
      .snd(snd3), .snd_stb(snd_stb3), .busy(busy3), .ovf(ovf3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (snd_stb0) stb_cnt++;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   typedef struct {
      logic [47:0] ch;
      logic [31:0] g;
      logic [3:0]  en;
      logic [15:0] exp;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Mixer rule: sum of enabled sample*gain, unity at 128, scaled to 16 bits, clamped.
   function automatic logic [15:0] ref_mix(input logic [47:0] ch, input logic [31:0] g, input logic [3:0] en);
      longint tot;
      longint m;
      tot = 0;
      for (int i = 0; i < 4; i++)
         if (en[i]) tot += longint'(ch[i*12 +: 12]) * longint'(g[i*8 +: 8]);
      m = (tot / 128) * 16;
      if (m > 65535) m = 65535;
      return 16'(m);
   endfunction

   // Filter rule: move by floor((mix - y) / 2^sh).
   function automatic logic [15:0] ref_flt(input logic [15:0] y, input logic [15:0] mix, input int sh);
      int d;
      int div;
      int step;
      if (sh == 0) return mix;
      d   = int'(mix) - int'(y);
      div = 1 << sh;
      step = (d >= 0) ? d / div : -((-d + div - 1) / div);
      return 16'(int'(y) + step);
   endfunction

   task automatic run_mix(input logic [47:0] ch, input logic [31:0] g, input logic [3:0] en, input bit chg_mid);
      int          k;
      logic [7:0]  bpat;
      logic [15:0] m;
      ch_in = ch;
      gain  = g;
      ch_en = en;
      m  = ref_mix(ch, g, en);
      y0 = ref_flt(y0, m, 0);
      y3 = ref_flt(y3, m, 3);
      m2 = 1'b0;
      k = 0;
      bpat = 8'h00;
      do begin
         @(negedge clk);
         k++;
         if (k <= 8) bpat[k-1] = busy0;
         if (chg_mid && k == 2) begin
            ch_in = 48'({$urandom, $urandom});
            gain  = $urandom;
            ch_en = 4'($urandom);
         end
      end while (!snd_stb0 && k < 20);
      chk("strobe_latency", 32'(k), 32'd8);
      chk("busy_window", 32'(bpat), 32'h7E);
      chk("snd_bypass", 32'(snd0), 32'(y0));
      chk("snd_filtered", 32'(snd3), 32'(y3));
      chk("stb_filtered", 32'(snd_stb3), 32'd1);
      m2 = 1'b1;
      @(negedge clk);
      chk("stb_one_cycle", 32'(snd_stb0), 32'd0);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int c0;
      int k;

      tbl[0] = '{48'h000_000_000_FFF, 32'h00_00_00_80, 4'b0001, 16'hFFF0};
      tbl[1] = '{48'hFFF_FFF_FFF_FFF, 32'hFF_FF_FF_FF, 4'b1111, 16'hFFFF};
      tbl[2] = '{{36'd0, 12'd1000},   {24'd0, 8'd64},  4'b0001, 16'd8000};
      tbl[3] = '{48'h123_456_789_ABC, 32'h80_80_80_80, 4'b0000, 16'h0000};
      tbl[4] = '{{12'd0, 12'd1024, 12'd2048, 12'd0}, {8'd0, 8'd64, 8'd128, 8'd0}, 4'b0110, 16'hA000};
      tbl[5] = '{{12'd100, 24'd0, 12'd4095}, {8'd0, 16'd0, 8'd1}, 4'b1001, 16'd496};
      tbl[6] = '{48'h000_000_000_FFF, 32'h00_00_00_81, 4'b0001, 16'hFFFF};
      tbl[7] = '{{24'd0, 12'd1, 12'd1}, {16'd0, 8'd1, 8'd127}, 4'b0011, 16'h0010};

      rst = 1'b1;
      m2 = 1'b1;
      ch_in = 48'd0;
      gain = 32'd0;
      ch_en = 4'd0;
      repeat (3) @(negedge clk);
      chk("reset_snd", 32'(snd0), 32'd0);
      chk("reset_busy", 32'(busy0), 32'd0);
      chk("reset_ovf", 32'(ovf0), 32'd0);
      chk("reset_stb", 32'(snd_stb0), 32'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Filter step from y=0, with inputs disturbed during the MAC on the second mix.
      run_mix({36'd0, 12'd1000}, {24'd0, 8'd64}, 4'b0001, 1'b0);
      chk("filter_step1", 32'(snd3), 32'd1000);
      run_mix({36'd0, 12'd1000}, {24'd0, 8'd64}, 4'b0001, 1'b1);
      chk("filter_step2", 32'(snd3), 32'd1875);
      chk("snapshot_bypass", 32'(snd0), 32'd8000);
      run_mix({36'd0, 12'd1000}, {24'd0, 8'd64}, 4'b0001, 1'b0);
      chk("filter_step3", 32'(snd3), 32'd2640);

      for (int i = 0; i < 8; i++) begin
         run_mix(tbl[i].ch, tbl[i].g, tbl[i].en, 1'b0);
         chk("table_bypass", 32'(snd0), 32'(tbl[i].exp));
      end

      for (int i = 0; i < 40; i++)
         run_mix(48'({$urandom, $urandom}), $urandom, 4'($urandom), 1'b0);

      // Second fall during MAC queues one extra mix.
      ch_in = {36'd0, 12'd1000};
      gain  = {24'd0, 8'd64};
      ch_en = 4'b0001;
      c0 = stb_cnt;
      m2 = 1'b0; @(negedge clk);
      m2 = 1'b1; @(negedge clk);
      m2 = 1'b0; @(negedge clk);
      m2 = 1'b1;
      repeat (30) @(negedge clk);
      y0 = ref_flt(y0, 16'd8000, 0); y0 = ref_flt(y0, 16'd8000, 0);
      y3 = ref_flt(y3, 16'd8000, 3); y3 = ref_flt(y3, 16'd8000, 3);
      chk("pend_strobes", 32'(stb_cnt - c0), 32'd2);
      chk("pend_no_ovf", 32'(ovf0), 32'd0);
      chk("pend_snd_bypass", 32'(snd0), 32'(y0));
      chk("pend_snd_filtered", 32'(snd3), 32'(y3));

      // Third fall while a start is already pending is dropped.
      c0 = stb_cnt;
      m2 = 1'b0; @(negedge clk);
      m2 = 1'b1; @(negedge clk);
      m2 = 1'b0; @(negedge clk);
      m2 = 1'b1; @(negedge clk);
      m2 = 1'b0; @(negedge clk);
      m2 = 1'b1;
      repeat (30) @(negedge clk);
      y3 = ref_flt(y3, 16'd8000, 3); y3 = ref_flt(y3, 16'd8000, 3);
      chk("drop_strobes", 32'(stb_cnt - c0), 32'd2);
      chk("drop_ovf", 32'(ovf0), 32'd1);
      chk("drop_ovf_filtered", 32'(ovf3), 32'd1);
      chk("drop_snd_filtered", 32'(snd3), 32'(y3));

      // Reset asserted during SAT.
      m2 = 1'b0;
      k = 0;
      repeat (6) begin @(negedge clk); k++; end
      chk("sat_busy_before_rst", 32'(busy0), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_snd", 32'(snd3), 32'd0);
      chk("rst_mid_snd_bypass", 32'(snd0), 32'd0);
      chk("rst_mid_busy", 32'(busy0), 32'd0);
      chk("rst_mid_ovf", 32'(ovf0), 32'd0);
      chk("rst_mid_stb", 32'(snd_stb0), 32'd0);
      c0 = stb_cnt;
      rst = 1'b0;
      m2 = 1'b1;
      repeat (15) @(negedge clk);
      chk("rise_no_strobe", 32'(stb_cnt - c0), 32'd0);
      y0 = 16'd0;
      y3 = 16'd0;
      run_mix({36'd0, 12'd1000}, {24'd0, 8'd64}, 4'b0001, 1'b0);
      chk("after_rst_mix", 32'(snd3), 32'd1000);

      // Disabled channels: output decays to zero.
      for (int i = 0; i < 80 && y3 != 16'd0; i++)
         run_mix(48'hFFF_FFF_FFF_FFF, 32'hFF_FF_FF_FF, 4'b0000, 1'b0);
      chk("decay_zero", 32'(snd3), 32'd0);
      chk("decay_bypass_zero", 32'(snd0), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
